// File: rtl/fifo_push_arbiter_if.sv
// Bundle of requester and FIFO write-port signals around fifo_push_arbiter.
// The master modport is the arbiter side; slave is the requester/FIFO side.
interface fifo_push_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] din_flat;
  logic [N_REQ-1:0]       ack;
  logic                   fifo_full;
  logic                   fifo_a_full;
  logic                   fifo_push;
  logic [WIDTH-1:0]       fifo_din;
  logic [IDW-1:0]         grant_id;

  modport master (
    input  req, din_flat, fifo_full, fifo_a_full,
    output ack, fifo_push, fifo_din, grant_id
  );

  modport slave (
    output req, din_flat, fifo_full, fifo_a_full,
    input  ack, fifo_push, fifo_din, grant_id
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers.
// Define FIFO_ARB_LOCK_EN to add a burst lock that keeps one owner for up to BURST grants.
module fifo_push_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  fifo_push_arbiter_if.master bus
);

  logic             can_push_s;
  logic             grant_s;
  logic [IDW-1:0]   rr_id_s;
  logic [IDW-1:0]   win_id_s;
  logic [N_REQ-1:0] ack_s;
  logic [WIDTH-1:0] din_arr_s [N_REQ];

  logic             fifo_push_q, fifo_push_d;
  logic [WIDTH-1:0] fifo_din_q, fifo_din_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [IDW-1:0]   last_q, last_d;

  // Unpack requester data slices.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      din_arr_s[k] = bus.din_flat[k*WIDTH +: WIDTH];
    end
  end

  // Scan downwards so the nearest requester after last_q is the final assignment.
  always_comb begin
    logic [IDW-1:0] idx;
    idx     = '0;
    rr_id_s = last_q;
    for (int i = N_REQ; i >= 1; i--) begin
      idx     = IDW'((int'(last_q) + i) % N_REQ);
      rr_id_s = bus.req[idx] ? idx : rr_id_s;
    end
  end

`ifdef FIFO_ARB_LOCK_EN
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e    state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [CW-1:0]  burst_cnt_q, burst_cnt_d;
  logic           owner_hold_s;

  assign owner_hold_s = (state_q == ST_LOCKED) && bus.req[owner_q];

  // Lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Lock next-state: a stall freezes everything; an owner that drops req hands over to RR.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          owner_d     = win_id_s;
          state_d     = (BURST > 1) ? ST_LOCKED : ST_IDLE;
          burst_cnt_d = (BURST > 1) ? CW'(1) : CW'(0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (!grant_s) begin
          if (can_push_s && !bus.req[owner_q]) begin
            state_d     = ST_IDLE;
            burst_cnt_d = '0;
          end else begin
            state_d = ST_LOCKED;
          end
        end else if (owner_hold_s) begin
          if ((burst_cnt_q + CW'(1)) >= CW'(BURST)) begin
            state_d     = ST_IDLE;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + CW'(1);
          end
        end else begin
          owner_d     = win_id_s;
          state_d     = (BURST > 1) ? ST_LOCKED : ST_IDLE;
          burst_cnt_d = (BURST > 1) ? CW'(1) : CW'(0);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  // Lock output: a locked owner still requesting wins outright.
  always_comb begin
    if (owner_hold_s) begin
      win_id_s = owner_q;
    end else begin
      win_id_s = rr_id_s;
    end
  end
`else
  assign win_id_s = rr_id_s;
`endif

  // Throttle against the FIFO flags, counting the push already in flight.
  always_comb begin
    ack_s      = '0;
    can_push_s = ~bus.fifo_full & ~(fifo_push_q & bus.fifo_a_full);
    grant_s    = can_push_s & (|bus.req);
    for (int k = 0; k < N_REQ; k++) begin
      ack_s[k] = grant_s & (win_id_s == IDW'(k));
    end
  end

  // Next values of the FIFO write port and round-robin pointer.
  always_comb begin
    fifo_push_d = grant_s;
    if (grant_s) begin
      fifo_din_d = din_arr_s[win_id_s];
      grant_id_d = win_id_s;
      last_d     = win_id_s;
    end else begin
      fifo_din_d = fifo_din_q;
      grant_id_d = grant_id_q;
      last_d     = last_q;
    end
  end

  // Write-port and pointer registers; last starts at N_REQ-1 so req[0] leads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_push_q <= 1'b0;
      fifo_din_q  <= '0;
      grant_id_q  <= '0;
      last_q      <= IDW'(N_REQ - 1);
    end else begin
      fifo_push_q <= fifo_push_d;
      fifo_din_q  <= fifo_din_d;
      grant_id_q  <= grant_id_d;
      last_q      <= last_d;
    end
  end

  assign bus.ack       = rst ? '0 : ack_s;
  assign bus.fifo_push = fifo_push_q;
  assign bus.fifo_din  = fifo_din_q;
  assign bus.grant_id  = grant_id_q;

endmodule
